// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an N-input combinational
// block in ascending order, samples its single output after a settle delay,
// builds the observed truth table and compares it with an expected table.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h84
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   resp,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   table_valid,
  output logic                   pass
);

  localparam int W = 1 << N_IN;
  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] STIM_MAX = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [W-1:0]   next_table;

  // Table as it will look once the current sample lands; pass is judged on it.
  always_comb begin
    next_table = table_out;
    next_table[stim] = resp;
  end

  // Sweep controller: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stim        <= '0;
      cnt         <= '0;
      table_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          stim <= '0;
          if (start) begin
            state       <= SWEEP;
            cnt         <= SETTLE_C;
            table_out   <= '0;
            table_valid <= 1'b0;
            pass        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            table_out <= next_table;
            if (stim != STIM_MAX) begin
              stim <= stim + 1'b1;
              cnt  <= SETTLE_C;
            end else begin
              // Terminal compare exits before stim could wrap.
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              table_valid <= 1'b1;
              pass        <= (next_table == EXPECTED);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          stim  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default 3-input instance plus a
// 2-input, zero-settle instance driving an AND gate.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       stuck = 1'b0;

  logic [2:0] stim;
  logic       resp, busy, done, table_valid, pass;
  logic [7:0] table_out;

  logic [1:0] stim2;
  logic       resp2, busy2, done2, table_valid2, pass2;
  logic [3:0] table_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Golden block: out=1 for {inp1,inp2,inp3} in {010,111}; optionally stuck at 0.
  assign resp  = stuck ? 1'b0 : (stim == 3'd2 || stim == 3'd7);
  assign resp2 = &stim2;

  truth_table_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .table_out(table_out),
    .table_valid(table_valid), .pass(pass)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0), .EXPECTED(4'h8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .table_out(table_out2),
    .table_valid(table_valid2), .pass(pass2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start low. Pulses start, follows all 24 cycles,
  // then checks the done cycle and the idle cycle after it.
  task automatic sweep(input logic [7:0] exp_tab, input logic exp_pass, input bit poke);
    start = 1'b1;
    @(posedge clk);                 // edge k
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 24; j++) begin
      chk("sweep_stim", 32'(stim), 32'(j / 3));
      chk("sweep_flags", {busy, done, table_valid, pass}, 4'b1000);
      if (poke) start = (j == 5);
      if (j < 23) @(negedge clk);
    end
    @(negedge clk);                 // after edge k+24
    chk("done_flags", {busy, done, table_valid, pass}, {3'b011, exp_pass});
    chk("done_table", 32'(table_out), 32'(exp_tab));
    chk("done_stim", 32'(stim), 32'd7);
    @(negedge clk);                 // after edge k+25
    chk("idle_flags", {busy, done, table_valid, pass}, {3'b001, exp_pass});
    chk("idle_table", 32'(table_out), 32'(exp_tab));
    chk("idle_stim", 32'(stim), 32'd0);
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    chk("rst_out", {stim, busy, done, table_valid, pass, table_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out", {stim, busy, done, table_valid, pass}, '0);
    end

    // Golden sweep
    sweep(8'h84, 1'b1, 1'b0);

    // Stuck-at-0 block
    stuck = 1'b1;
    sweep(8'h00, 1'b0, 1'b0);
    stuck = 1'b0;

    // Start pulse during the sweep is ignored
    sweep(8'h84, 1'b1, 1'b1);

    // Start held high: re-arms on the first idle cycle
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 25; j++) @(negedge clk);  // after edge k+24
    chk("held_done", {busy, done, table_valid, pass}, 4'b0111);
    @(negedge clk);                                // after k+25: idle
    chk("held_idle", {busy, done, table_valid, stim}, {3'b001, 3'd0});
    @(negedge clk);                                // after k+26: accepted
    chk("held_accept", {busy, done, table_valid, pass}, 4'b1000);
    chk("held_clear", 32'(table_out), 32'd0);
    start = 1'b0;
    for (int j = 0; j < 24; j++) @(negedge clk);
    chk("held_done2", {busy, done, table_valid, pass}, 4'b0111);
    chk("held_table2", 32'(table_out), 32'h84);
    @(negedge clk);

    // Asynchronous reset mid-sweep
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 12; j++) @(negedge clk);
    chk("pre_rst_stim", 32'(stim), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {stim, busy, done, table_valid, pass, table_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", {stim, busy, done, table_valid, pass}, '0);
    sweep(8'h84, 1'b1, 1'b0);

    // 2-input AND, zero settle
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("and_stim", 32'(stim2), 32'(j));
      chk("and_busy", {busy2, done2}, 2'b10);
      if (j < 3) @(negedge clk);
    end
    @(negedge clk);
    chk("and_done", {busy2, done2, table_valid2, pass2}, 4'b0111);
    chk("and_table", 32'(table_out2), 32'h8);
    @(negedge clk);
    chk("and_idle", {busy2, done2, table_valid2, pass2, stim2}, {4'b0011, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
